// File: rtl/vga_ball_renderer_if.sv
// Bundle between the VGA sync generator (master) and the ball renderer (slave).
// Optional pause input appears only when VGA_PAUSE_EN is defined.
interface vga_ball_renderer_if;
  logic [10:0] counter_x;
  logic [8:0]  counter_y;
  logic        in_display;
  logic        vga_h_sync_in;
  logic        vga_v_sync_in;
`ifdef VGA_PAUSE_EN
  logic        pause;
`endif
  logic        vga_r;
  logic        vga_g;
  logic        vga_b;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic        frame_tick;

  modport master (
`ifdef VGA_PAUSE_EN
    output pause,
`endif
    output counter_x, counter_y, in_display, vga_h_sync_in, vga_v_sync_in,
    input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_tick
  );

  modport slave (
`ifdef VGA_PAUSE_EN
    input  pause,
`endif
    input  counter_x, counter_y, in_display, vga_h_sync_in, vga_v_sync_in,
    output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_tick
  );
endinterface

// File: rtl/vga_ball_renderer.sv
// Bouncing-ball pixel stage behind the VGA sync generator: 2-clk pipeline from counters
// to RGB, syncs re-timed by the same 2 flops, ball moved once per frame in vblank.
// Optional feature macro: VGA_PAUSE_EN (adds bus.pause, which freezes ball motion).
module vga_ball_renderer (
  input logic               clk,
  input logic               rst,
  vga_ball_renderer_if.slave bus
);
  localparam int unsigned HPixels  = 640;
  localparam int unsigned VPixels  = 480;
  localparam int unsigned BallSize = 16;
  localparam int unsigned Border   = 8;
  localparam int unsigned Step     = 2;
  localparam int unsigned XMin     = Border;
  localparam int unsigned XMax     = HPixels - Border - BallSize;
  localparam int unsigned YMin     = Border;
  localparam int unsigned YMax     = VPixels - Border - BallSize;
  localparam logic [9:0]  BallX0   = 10'((HPixels - BallSize) / 2);
  localparam logic [8:0]  BallY0   = 9'((VPixels - BallSize) / 2);

  typedef enum logic [1:0] {StIdle, StMoveX, StMoveY} state_e;

  state_e      state_q;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [8:0]  ball_y_q, ball_y_d;
  logic        dir_x_q, dir_x_d;  // 1 = right
  logic        dir_y_q, dir_y_d;  // 1 = down
  logic        armed_q;
  logic        frame_tick_q;

  logic [9:0]  px;
  logic [8:0]  py;
  logic [10:0] ball_x_end, x_sum;
  logic [9:0]  ball_y_end, y_sum;
  logic        in_ball, in_border, trigger, move_en;

  logic        in_ball_q, in_border_q, in_disp_q, h_sync1_q, v_sync1_q;
  logic        r_q, g_q, b_q, h_sync2_q, v_sync2_q;
  logic [2:0]  rgb_d;

  assign px = bus.counter_x[10:1];
  assign py = bus.counter_y;

`ifdef VGA_PAUSE_EN
  assign move_en = ~bus.pause;
`else
  assign move_en = 1'b1;
`endif

  // First blanking row, column 0: one move per frame
  assign trigger = (bus.counter_y == 9'(VPixels)) && (bus.counter_x == 11'd0);

  // Hit tests on the current pixel (unsigned, sums one bit wider)
  always_comb begin
    ball_x_end = {1'b0, ball_x_q} + 11'(BallSize);
    ball_y_end = {1'b0, ball_y_q} + 10'(BallSize);
    in_ball    = (px >= ball_x_q) && ({1'b0, px} < ball_x_end) &&
                 (py >= ball_y_q) && ({1'b0, py} < ball_y_end);
    in_border  = (px < 10'(Border)) || (px >= 10'(HPixels - Border)) ||
                 (py < 9'(Border))  || (py >= 9'(VPixels - Border));
  end

  // Next ball position/direction; compare before subtract so nothing wraps
  always_comb begin
    ball_x_d = ball_x_q;
    dir_x_d  = dir_x_q;
    ball_y_d = ball_y_q;
    dir_y_d  = dir_y_q;
    x_sum    = {1'b0, ball_x_q} + 11'(Step);
    y_sum    = {1'b0, ball_y_q} + 10'(Step);
    if (dir_x_q) begin
      if (x_sum >= 11'(XMax)) begin
        ball_x_d = 10'(XMax);
        dir_x_d  = 1'b0;
      end else begin
        ball_x_d = x_sum[9:0];
      end
    end else if (ball_x_q <= 10'(XMin + Step)) begin
      ball_x_d = 10'(XMin);
      dir_x_d  = 1'b1;
    end else begin
      ball_x_d = ball_x_q - 10'(Step);
    end
    if (dir_y_q) begin
      if (y_sum >= 10'(YMax)) begin
        ball_y_d = 9'(YMax);
        dir_y_d  = 1'b0;
      end else begin
        ball_y_d = y_sum[8:0];
      end
    end else if (ball_y_q <= 9'(YMin + Step)) begin
      ball_y_d = 9'(YMin);
      dir_y_d  = 1'b1;
    end else begin
      ball_y_d = ball_y_q - 9'(Step);
    end
  end

  // Motion FSM: IDLE -> MOVE_X -> MOVE_Y -> IDLE, registered frame_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ball_x_q     <= BallX0;
      ball_y_q     <= BallY0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      armed_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      // Re-arm once the counters leave the trigger row
      if (bus.counter_y != 9'(VPixels)) armed_q <= 1'b1;
      frame_tick_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trigger && armed_q) begin
            state_q      <= StMoveX;
            armed_q      <= 1'b0;
            frame_tick_q <= 1'b1;
          end
        end
        StMoveX: begin
          state_q <= StMoveY;
          if (move_en) begin
            ball_x_q <= ball_x_d;
            dir_x_q  <= dir_x_d;
          end
        end
        StMoveY: begin
          state_q <= StIdle;
          if (move_en) begin
            ball_y_q <= ball_y_d;
            dir_y_q  <= dir_y_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // S1: hit-test results plus first sync delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ball_q   <= 1'b0;
      in_border_q <= 1'b0;
      in_disp_q   <= 1'b0;
      h_sync1_q   <= 1'b1;
      v_sync1_q   <= 1'b1;
    end else begin
      in_ball_q   <= in_ball;
      in_border_q <= in_border;
      in_disp_q   <= bus.in_display;
      h_sync1_q   <= bus.vga_h_sync_in;
      v_sync1_q   <= bus.vga_v_sync_in;
    end
  end

  // Colour select: blanking, then ball over border
  always_comb begin
    rgb_d = 3'b000;
    if (!in_disp_q)       rgb_d = 3'b000;
    else if (in_ball_q)   rgb_d = 3'b111;
    else if (in_border_q) rgb_d = 3'b001;
  end

  // S2: RGB plus second sync delay, keeping edges aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= 1'b0;
      g_q       <= 1'b0;
      b_q       <= 1'b0;
      h_sync2_q <= 1'b1;
      v_sync2_q <= 1'b1;
    end else begin
      {r_q, g_q, b_q} <= rgb_d;
      h_sync2_q       <= h_sync1_q;
      v_sync2_q       <= v_sync1_q;
    end
  end

  assign bus.vga_r      = r_q;
  assign bus.vga_g      = g_q;
  assign bus.vga_b      = b_q;
  assign bus.vga_h_sync = h_sync2_q;
  assign bus.vga_v_sync = v_sync2_q;
  assign bus.frame_tick = frame_tick_q;
endmodule
